serial_adder_ctrl: RTL and testbench

- Bit-serial adder controller: accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake.
- Time-multiplexes a single 1-bit full-adder stage across WIDTH cycles, LSB first, and returns the WIDTH-bit sum and carry-out over a second valid/ready handshake.
- Area-saving replacement for a WIDTH-bit ripple adder on non-critical paths; sits between a requesting unit and its result consumer.

---
 rtl/serial_adder_ctrl.sv | 148 ++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder stage reused for WIDTH cycles, LSB first.
// Optional subtract mode is enabled with the SERIAL_ADDER_CTRL_SUB_EN macro (adds port op_sub).
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_ADDER_CTRL_SUB_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  // state  | meaning
  // IDLE   | ready for operands; last result held on sum/c_out
  // RUN    | one result bit per cycle, WIDTH cycles
  // DONE   | result presented, waiting for out_ready
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] ps_q, ps_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             accept;
  logic             last_bit;
  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] ps_next;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  assign fa_s    = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign fa_co   = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
  assign ps_next = {fa_s, ps_q[WIDTH-1:1]};

  assign accept   = in_valid & in_ready;
  assign last_bit = (state_q == S_RUN) && (cnt_q == LAST_BIT);

  // Subtraction is a + ~b + 1, so only the B operand and the initial carry change.
`ifdef SERIAL_ADDER_CTRL_SUB_EN
  assign b_load     = op_sub ? ~b : b;
  assign carry_load = op_sub ? 1'b1 : c_in;
`else
  assign b_load     = b;
  assign carry_load = c_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept)    state_d = S_RUN;
      S_RUN:  if (last_bit)  state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    ps_d    = ps_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_sh_d  = a;
          b_sh_d  = b_load;
          ps_d    = '0;
          carry_d = carry_load;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        ps_d    = ps_next;
        carry_d = fa_co;
        cnt_d   = cnt_q + CW'(1);
        if (last_bit) begin
          sum_d   = ps_next;
          c_out_d = fa_co;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      ps_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      ps_q    <= ps_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
    end
  end

  assign sum   = sum_q;
  assign c_out = c_out_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH = 8): directed table, corner sequences, random ops.
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         op_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         c_out;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] last_sum = '0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
`ifdef SERIAL_ADDER_CTRL_SUB_EN
    .op_sub    (op_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: whole-word arithmetic, {carry/no-borrow, result}.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic ci, input logic sub);
    logic [W-1:0] d;
    int unsigned  t;
    if (sub) begin
      d = x - y;
      return {(x >= y), d};
    end
    t = int'(x) + int'(y) + int'(ci);
    return t[W:0];
  endfunction

  task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc, input logic xs);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    a = xa; b = xb; c_in = xc; op_sub = xs;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); c_in = 1'($urandom); op_sub = 1'b0;
  endtask

  task automatic wait_result(input logic [W-1:0] es, input logic eco, input logic junk);
    int lat = 0;
    while (!out_valid && lat < 4 * W) begin
      check("in_ready_busy", in_ready, 0);
      check("sum_hold_run", sum, last_sum);
      if (junk) begin
        in_valid = 1'b1; a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check("latency", lat, W);
    check("sum", sum, es);
    check("c_out", c_out, eco);
    last_sum = es;
  endtask

  task automatic finish_op(input int hold);
    for (int k = 0; k < hold; k++) begin
      check("out_valid_hold", out_valid, 1);
      check("sum_hold_bp", sum, last_sum);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 0);
    check("in_ready_back", in_ready, 1);
    check("sum_hold_idle", sum, last_sum);
  endtask

  vec_t tbl[8];
  logic [W:0] exp_r;

  initial begin
    tbl[0] = '{a: 8'h3C, b: 8'h05, ci: 1'b0, s: 8'h41, co: 1'b0};
    tbl[1] = '{a: 8'hFF, b: 8'h01, ci: 1'b0, s: 8'h00, co: 1'b1};
    tbl[2] = '{a: 8'hFF, b: 8'hFF, ci: 1'b1, s: 8'hFF, co: 1'b1};
    tbl[3] = '{a: 8'h00, b: 8'h00, ci: 1'b1, s: 8'h01, co: 1'b0};
    tbl[4] = '{a: 8'h80, b: 8'h80, ci: 1'b0, s: 8'h00, co: 1'b1};
    tbl[5] = '{a: 8'hAA, b: 8'h55, ci: 1'b0, s: 8'hFF, co: 1'b0};
    tbl[6] = '{a: 8'h7F, b: 8'h01, ci: 1'b1, s: 8'h81, co: 1'b0};
    tbl[7] = '{a: 8'h10, b: 8'h20, ci: 1'b0, s: 8'h30, co: 1'b0};

    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_c_out", c_out, 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      send(tbl[i].a, tbl[i].b, tbl[i].ci, 1'b0);
      wait_result(tbl[i].s, tbl[i].co, 1'b0);
      finish_op(0);
    end

    // Backpressure with new operands offered the whole time
    send(8'h3C, 8'h05, 1'b0, 1'b0);
    wait_result(8'h41, 1'b0, 1'b0);
    in_valid = 1'b1; a = 8'h77; b = 8'h11; c_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_sum", sum, 8'h41);
      check("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_out_valid", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_next_taken", in_ready, 0);
    wait_result(8'h88, 1'b0, 1'b0);
    finish_op(0);

    // Asynchronous reset after 3 RUN cycles
    send(8'h3C, 8'h05, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_rst_in_ready", in_ready, 1);
    check("midrun_rst_out_valid", out_valid, 0);
    check("midrun_rst_sum", sum, 0);
    check("midrun_rst_c_out", c_out, 0);
    last_sum = '0;
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h10, 8'h20, 1'b0, 1'b0);
    wait_result(8'h30, 1'b0, 1'b0);
    finish_op(0);

`ifdef SERIAL_ADDER_CTRL_SUB_EN
    send(8'h10, 8'h01, 1'b0, 1'b1);
    wait_result(8'h0F, 1'b1, 1'b0);
    finish_op(0);
    send(8'h01, 8'h02, 1'b0, 1'b1);
    wait_result(8'hFF, 1'b0, 1'b0);
    finish_op(0);
    send(8'h10, 8'h01, 1'b1, 1'b1);
    wait_result(8'h0F, 1'b1, 1'b0);
    finish_op(0);
`endif

    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] ra, rb;
      logic rc, rs;
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
`ifdef SERIAL_ADDER_CTRL_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      exp_r = model(ra, rb, rc, rs);
      send(ra, rb, rc, rs);
      wait_result(exp_r[W-1:0], exp_r[W], 1'($urandom));
      finish_op(int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
